// File: rtl/sram_rd_streamer_if.sv
// Bus bundle for sram_rd_streamer: burst request, SRAM read port and
// output word stream.
//   req_*   : burst request (valid/ready, start address, word count)
//   sram_*  : read port toward dual_port_sram (rd_en/rd_addr out, dout back)
//   out_*   : valid/ready word stream toward egress (data, last-of-burst)
// Modports:
//   slave  - the streamer block itself
//   master - the environment around it (requester, SRAM, egress sink)
interface sram_rd_streamer_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 10
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LEN_WIDTH-1:0]  req_len;

  logic                  sram_rd_en;
  logic [ADDR_WIDTH-1:0] sram_rd_addr;
  logic [DATA_WIDTH-1:0] sram_dout;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport slave (
    input  req_valid, req_addr, req_len, sram_dout, out_ready,
    output req_ready, sram_rd_en, sram_rd_addr, out_valid, out_data, out_last
  );

  modport master (
    output req_valid, req_addr, req_len, sram_dout, out_ready,
    input  req_ready, sram_rd_en, sram_rd_addr, out_valid, out_data, out_last
  );
endinterface

// File: rtl/sram_rd_streamer.sv
// Read-side streamer behind dual_port_sram. Takes a burst request (start
// address, word count), issues sequential SRAM reads with address wrap,
// absorbs the SRAM's one-cycle read latency in a small credit-managed FIFO
// and presents the words on a valid/ready stream, one word per cycle.
// Ports:
//   clk   - block clock
//   rst   - synchronous reset, active-high
//   bus   - sram_rd_streamer_if.slave (request, SRAM read port, out stream)
//   busy  - burst in progress (FSM not idle)
//   done  - one-cycle pulse when the burst has been fully delivered
//
// state | meaning
// IDLE  | waiting for a request; req_ready high
// READ  | issuing SRAM reads as FIFO credit allows
// DRAIN | last read issued; waiting for the last word to be popped
module sram_rd_streamer #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  sram_rd_streamer_if.slave  bus,
  output logic               busy,
  output logic               done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CRD_W = CNT_W + 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic                  zlen_q, zlen_d;

  logic                  rd_en_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic                  rd_last_q;
  logic                  inflight_q;
  logic                  inflight_last_q;

  logic                  issue;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic                  issue_last;

  logic [DATA_WIDTH:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  push, pop;
  logic                  out_valid;
  logic                  head_last;
  logic [DATA_WIDTH-1:0] head_data;
  logic [CRD_W-1:0]      credit_used;
  logic                  credit_ok;
  logic                  accept;

  assign out_valid = (count_q != '0);
  assign head_data = fifo_mem[rd_ptr_q][DATA_WIDTH-1:0];
  assign head_last = fifo_mem[rd_ptr_q][DATA_WIDTH];
  assign push      = inflight_q;
  assign pop       = out_valid && bus.out_ready;
  assign accept    = bus.req_valid && bus.req_ready;

  // Reads are registered, so a read decided now lands in the FIFO two
  // edges later. Count the stored words, the word returning this cycle and
  // the read currently on the SRAM port; pops are ignored (conservative),
  // which still sustains one word per cycle for depth >= 4.
  assign credit_used = CRD_W'(count_q) + CRD_W'(inflight_q) + CRD_W'(rd_en_q);
  assign credit_ok   = credit_used < CRD_W'(FIFO_DEPTH);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    zlen_d     = 1'b0;
    issue      = 1'b0;
    issue_addr = addr_q;
    issue_last = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.req_len == '0) begin
            zlen_d = 1'b1;
          end else begin
            // FIFO is empty after the previous burst, so the first read
            // goes out on the accept edge.
            issue      = 1'b1;
            issue_addr = bus.req_addr;
            issue_last = (bus.req_len == LEN_WIDTH'(1));
            addr_d     = bus.req_addr + ADDR_WIDTH'(1);
            rem_d      = bus.req_len - LEN_WIDTH'(1);
            state_d    = (bus.req_len == LEN_WIDTH'(1)) ? DRAIN : READ;
          end
        end
      end
      READ: begin
        if ((rem_q != '0) && credit_ok) begin
          issue      = 1'b1;
          issue_last = (rem_q == LEN_WIDTH'(1));
          addr_d     = addr_q + ADDR_WIDTH'(1);
          rem_d      = rem_q - LEN_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      rem_q           <= '0;
      zlen_q          <= 1'b0;
      rd_en_q         <= 1'b0;
      rd_addr_q       <= '0;
      rd_last_q       <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      rem_q           <= rem_d;
      zlen_q          <= zlen_d;
      rd_en_q         <= issue;
      rd_addr_q       <= issue ? issue_addr : rd_addr_q;
      rd_last_q       <= issue && issue_last;
      inflight_q      <= rd_en_q;
      inflight_last_q <= rd_en_q && rd_last_q;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: contents are only visible while count_q != 0.
  always_ff @(posedge clk) begin
    if (push && !rst) fifo_mem[wr_ptr_q] <= {inflight_last_q, bus.sram_dout};
  end

  assign bus.req_ready    = (state_q == IDLE) && !rst;
  assign bus.sram_rd_en   = rd_en_q;
  assign bus.sram_rd_addr = rd_addr_q;
  assign bus.out_valid    = out_valid;
  assign bus.out_data     = out_valid ? head_data : '0;
  assign bus.out_last     = out_valid && head_last;
  assign busy             = (state_q != IDLE);
  assign done             = !rst && (zlen_q || ((state_q == DRAIN) && pop && head_last));

endmodule

// File: tb/tb_sram_rd_streamer.sv
module tb_sram_rd_streamer;

  logic clk = 1'b0;
  logic rst;
  logic busy, done;

  int checks = 0;
  int errors = 0;

  sram_rd_streamer_if #(.ADDR_WIDTH(14), .DATA_WIDTH(16), .LEN_WIDTH(10)) bus ();

  sram_rd_streamer #(.ADDR_WIDTH(14), .DATA_WIDTH(16), .LEN_WIDTH(10), .FIFO_DEPTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] mem_f(input logic [13:0] a);
    return {a, 2'b01} ^ 16'h5A00;
  endfunction

  // SRAM model: registered read, word valid the cycle after rd_en. Not reset,
  // so it keeps returning words across a streamer reset.
  always @(posedge clk) begin
    if (bus.sram_rd_en) bus.sram_dout <= mem_f(bus.sram_rd_addr);
  end

  logic [13:0] rd_q[$];
  logic [15:0] pd_q[$];
  bit          pl_q[$];
  int          done_cnt, issued, popped, max_out;
  bit          ov_seen;

  always @(negedge clk) begin
    if (bus.sram_rd_en) begin
      rd_q.push_back(bus.sram_rd_addr);
      issued++;
    end
    if (issued - popped > max_out) max_out = issued - popped;
    if (bus.out_valid) ov_seen = 1'b1;
    if (bus.out_valid && bus.out_ready) begin
      pd_q.push_back(bus.out_data);
      pl_q.push_back(bus.out_last);
      popped++;
    end
    if (done) done_cnt++;
  end

  task automatic clear_mon();
    rd_q.delete();
    pd_q.delete();
    pl_q.delete();
    done_cnt = 0;
    issued   = 0;
    popped   = 0;
    max_out  = 0;
    ov_seen  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int budget, input bit toggle, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (toggle) bus.out_ready = ~bus.out_ready;
      #1;
      if (done) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd1);
    tick();
  endtask

  task automatic send_req(input logic [13:0] a, input logic [9:0] l);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_len   = l;
  endtask

  task automatic chk_burst(input string tag, input logic [13:0] a, input int n);
    logic [13:0] ea;
    chk({tag, "_nrd"}, 32'(rd_q.size()), 32'(n));
    chk({tag, "_npop"}, 32'(pd_q.size()), 32'(n));
    for (int i = 0; i < n && i < pd_q.size() && i < rd_q.size(); i++) begin
      ea = a + 14'(i);
      chk({tag, "_addr"}, 32'(rd_q[i]), 32'(ea));
      chk({tag, "_data"}, 32'(pd_q[i]), 32'(mem_f(ea)));
      chk({tag, "_last"}, 32'(pl_q[i]), 32'(i == n - 1));
    end
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
  endtask

  initial begin
    logic [15:0] head0;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.out_ready = 1'b0;
    clear_mon();

    // reset state
    tick();
    tick();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rd_en", 32'(bus.sram_rd_en), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_req_ready", 32'(bus.req_ready), 32'd1);

    // 1: cycle-exact latency, addr 0x10 len 4
    clear_mon();
    bus.out_ready = 1'b1;
    send_req(14'h0010, 10'd4);
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) bus.req_valid = 1'b0;
      #1;
      chk("t1_rd_en", 32'(bus.sram_rd_en), 32'(c <= 4));
      if (c <= 4) chk("t1_rd_addr", 32'(bus.sram_rd_addr), 32'(14'h0010 + 14'(c - 1)));
      chk("t1_out_valid", 32'(bus.out_valid), 32'(c >= 3 && c <= 6));
      chk("t1_out_data", 32'(bus.out_data),
          (c >= 3 && c <= 6) ? 32'(mem_f(14'h0010 + 14'(c - 3))) : 32'd0);
      chk("t1_out_last", 32'(bus.out_last), 32'(c == 6));
      chk("t1_done", 32'(done), 32'(c == 6));
      chk("t1_busy", 32'(busy), 32'(c <= 6));
      chk("t1_req_ready", 32'(bus.req_ready), 32'(c == 7));
    end
    chk_burst("t1", 14'h0010, 4);

    // 2: address wrap
    clear_mon();
    send_req(14'h3FFE, 10'd4);
    tick();
    bus.req_valid = 1'b0;
    wait_done(30, 1'b0, "t2_done_seen");
    chk_burst("t2", 14'h3FFE, 4);
    chk("t2_wrap_addr2", 32'(rd_q.size() > 2 ? rd_q[2] : 14'h3FFF), 32'h0000);

    // 3: backpressure, FIFO fills, reads stop at depth
    clear_mon();
    bus.out_ready = 1'b0;
    send_req(14'h0100, 10'd8);
    tick();
    bus.req_valid = 1'b0;
    head0 = '0;
    for (int i = 2; i <= 10; i++) begin
      tick();
      if (i == 4) head0 = bus.out_data;
    end
    chk("t3_rd_count_stalled", 32'(rd_q.size()), 32'd4);
    chk("t3_rd_en_held_low", 32'(bus.sram_rd_en), 32'd0);
    chk("t3_out_valid", 32'(bus.out_valid), 32'd1);
    chk("t3_head_early", 32'(head0), 32'(mem_f(14'h0100)));
    chk("t3_head_late", 32'(bus.out_data), 32'(mem_f(14'h0100)));
    bus.out_ready = 1'b1;
    wait_done(40, 1'b0, "t3_done_seen");
    chk_burst("t3", 14'h0100, 8);
    chk("t3_outstanding_le_depth", 32'(max_out <= 4), 32'd1);

    // 4: toggling out_ready
    clear_mon();
    send_req(14'h2000, 10'd16);
    tick();
    bus.req_valid = 1'b0;
    wait_done(200, 1'b1, "t4_done_seen");
    bus.out_ready = 1'b1;
    chk_burst("t4", 14'h2000, 16);
    chk("t4_outstanding_le_depth", 32'(max_out <= 4), 32'd1);

    // 5: zero-length request
    clear_mon();
    send_req(14'h0123, 10'd0);
    tick();
    bus.req_valid = 1'b0;
    #1;
    chk("t5_done_c1", 32'(done), 32'd1);
    chk("t5_busy_c1", 32'(busy), 32'd0);
    chk("t5_req_ready_c1", 32'(bus.req_ready), 32'd1);
    for (int i = 0; i < 5; i++) tick();
    chk("t5_done_cnt", 32'(done_cnt), 32'd1);
    chk("t5_no_reads", 32'(rd_q.size()), 32'd0);
    chk("t5_no_out_valid", 32'(ov_seen), 32'd0);

    // 6: reset mid-burst, then a fresh burst
    clear_mon();
    send_req(14'h0300, 10'd8);
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 30 && pd_q.size() < 3; i++) tick();
    chk("t6_three_words", 32'(pd_q.size()), 32'd3);
    rst = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    chk("t6_rst_rd_en", 32'(bus.sram_rd_en), 32'd0);
    chk("t6_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_rst_out_last", 32'(bus.out_last), 32'd0);
    chk("t6_rst_out_data", 32'(bus.out_data), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    chk("t6_rst_req_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;
    tick();
    chk("t6_req_ready_after", 32'(bus.req_ready), 32'd1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("t6_no_stale_words", 32'(pd_q.size()), 32'd3);
    clear_mon();
    send_req(14'h0050, 10'd2);
    tick();
    bus.req_valid = 1'b0;
    wait_done(30, 1'b0, "t6_done_seen");
    chk_burst("t6", 14'h0050, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
